// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store stage downstream of the ALU.
//
// Accepts one load or store per start strobe and runs a single handshaked
// data-memory transaction. Stores get lane-replicated data and byte strobes;
// loads get lane selection plus sign/zero extension. Completion is a one-cycle
// done pulse carrying either the writeback value or an error cause.
//
// Optional feature macro: LSU_TIMEOUT_EN. When defined, a transaction that
// waits TIMEOUT_CYCLES cycles in REQ without mem_ready_i is abandoned and
// completes with cause 3. When undefined, REQ waits indefinitely.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                request strobe (sampled in IDLE only)
//   is_load_i, is_store_i  operation type (exactly one must be set)
//   funct3_i               width/sign: 0=B 1=H 2=W 4=BU 5=HU
//   address_i              effective address
//   store_data_i           rs2 value
//   busy_o                 transaction in flight (through the done cycle)
//   done_o                 one-cycle completion pulse
//   load_result_o          extended load data, held until the next good load
//   err_cause_o            0=none 1=misaligned 2=illegal width 3=bus timeout
//   mem_req_o .. mem_wstrb_o  memory request side
//   mem_ready_i, mem_rdata_i  memory response side

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] address_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_result_o,
  output logic [1:0]  err_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrMisalign = 2'd1;
  localparam logic [1:0] ErrWidth    = 2'd2;
  localparam logic [1:0] ErrTimeout  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] load_result_q, load_result_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        tmo_expire;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Exactly one of load/store must be requested; anything else is dropped.
  assign accept = (state_q == StIdle) && start_i && (is_load_i ^ is_store_i);

  always_comb begin
    illegal = 1'b0;
    if (is_load_i) begin
      illegal = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
    end else begin
      illegal = (funct3_i >= 3'd3);
    end
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (funct3_i[1:0])
      2'd1:    misaligned = address_i[0];
      2'd2:    misaligned = (address_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  // Counter sits at zero outside REQ, so it is clear on every entry to REQ.
  localparam logic [15:0] TmoLast =
      (TIMEOUT_CYCLES > 1) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_cnt_d  = (state_q == StReq) ? (tmo_cnt_q + 16'd1) : 16'd0;
  assign tmo_expire = (state_q == StReq) && (tmo_cnt_q >= TmoLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expire         = 1'b0;
`endif

  // Load lane select and extension, using the latched offset and width.
  always_comb begin
    lane_byte = 8'h00;
    unique case (off_q)
      2'd0: lane_byte = mem_rdata_i[7:0];
      2'd1: lane_byte = mem_rdata_i[15:8];
      2'd2: lane_byte = mem_rdata_i[23:16];
      2'd3: lane_byte = mem_rdata_i[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_ext = {{16{lane_half[15]}}, lane_half};
      3'd4:    load_ext = {24'h000000, lane_byte};
      3'd5:    load_ext = {16'h0000, lane_half};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    load_result_d = load_result_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    funct3_d      = funct3_q;
    off_d         = off_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (illegal) begin
            err_d   = ErrWidth;
            state_d = StResp;
          end else if (misaligned) begin
            err_d   = ErrMisalign;
            state_d = StResp;
          end else begin
            err_d    = ErrNone;
            state_d  = StReq;
            we_d     = is_store_i;
            addr_d   = {address_i[31:2], 2'b00};
            funct3_d = funct3_i;
            off_d    = address_i[1:0];
            if (is_store_i) begin
              unique case (funct3_i[1:0])
                2'd0: begin
                  wdata_d = {4{store_data_i[7:0]}};
                  wstrb_d = 4'b0001 << address_i[1:0];
                end
                2'd1: begin
                  wdata_d = {2{store_data_i[15:0]}};
                  wstrb_d = 4'b0011 << address_i[1:0];
                end
                default: begin
                  wdata_d = store_data_i;
                  wstrb_d = 4'b1111;
                end
              endcase
            end else begin
              wdata_d = 32'h0;
              wstrb_d = 4'b0000;
            end
          end
        end
      end
      StReq: begin
        // A ready arriving in the expiry cycle still completes normally.
        if (mem_ready_i) begin
          state_d = StResp;
          if (!we_q) begin
            load_result_d = load_ext;
          end
        end else if (tmo_expire) begin
          state_d = StResp;
          err_d   = ErrTimeout;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      err_q         <= ErrNone;
      load_result_q <= 32'h0;
      we_q          <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'b0000;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      load_result_q <= load_result_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
    end
  end

  // mem_req_o decodes straight from state so reset drops it without a clock.
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StResp);
  assign mem_req_o     = (state_q == StReq);
  assign err_cause_o   = err_q;
  assign load_result_o = load_result_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions checked against a behavioural model of the access rules.

module tb_load_store_unit;

  localparam int TMO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] address = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] load_result, mem_addr, mem_wdata;
  logic [1:0]  err_cause;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_result = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .is_load_i    (is_load),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .address_i    (address),
    .store_data_i (store_data),
    .busy_o       (busy),
    .done_o       (done),
    .load_result_o(load_result),
    .err_cause_o  (err_cause),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wstrb_o  (mem_wstrb),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outcome of one access, derived from the width/alignment rules.
  function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output int cause, output logic [31:0] wd,
                                output logic [3:0] ws, output logic [31:0] res);
    int size;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    off  = int'(a % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mask = (64'd1 << (8 * size)) - 64'd1;
    if (ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 >= 3)) cause = 2;
    else if ((off % size) != 0) cause = 1;
    else cause = 0;
    v = 64'h0;
    for (int i = 0; i < 4; i += size) v = v | ((64'(sd) & mask) << (8 * i));
    wd = v[31:0];
    ws = ld ? 4'b0000 : 4'(((1 << size) - 1) << off);
    v  = (64'(rd) >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    res = v[31:0];
  endfunction

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                        input int delay, input bit poke);
    int cause;
    logic [31:0] wd, res;
    logic [3:0] ws;
    int req_cycles;
    bit tmo;
    model(ld, f3, a, sd, rd, cause, wd, ws, res);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; address = a; store_data = sd;
    mem_ready = (delay == 0);
    mem_rdata = (delay == 0) ? rd : $urandom;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); address = $urandom; store_data = $urandom;
    if (ld == st) begin
      check_eq("ignored_busy", 32'(busy), 32'd0);
      check_eq("ignored_req", 32'(mem_req), 32'd0);
      mem_ready = 1'b0;
      return;
    end
    if (cause != 0) begin
      check_eq("err_done", 32'(done), 32'd1);
      check_eq("err_cause", 32'(err_cause), 32'(cause));
      check_eq("err_no_req", 32'(mem_req), 32'd0);
      check_eq("err_result_held", load_result, exp_result);
      mem_ready = 1'b0;
      @(posedge clk); #1;
      check_eq("err_done_pulse", 32'(done), 32'd0);
      check_eq("err_idle", 32'(busy), 32'd0);
      return;
    end
    tmo = TMO_EN && (delay >= TMO);
    req_cycles = tmo ? TMO : delay + 1;
    for (int c = 0; c < req_cycles; c++) begin
      check_eq("req_high", 32'(mem_req), 32'd1);
      check_eq("req_no_done", 32'(done), 32'd0);
      check_eq("req_busy", 32'(busy), 32'd1);
      check_eq("req_addr", mem_addr, {a[31:2], 2'b00});
      check_eq("req_we", 32'(mem_we), 32'(st));
      check_eq("req_wstrb", 32'(mem_wstrb), 32'(ws));
      if (st) check_eq("req_wdata", mem_wdata, wd);
      if (poke) begin
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; address = 32'h40;
      end
      mem_ready = (c == delay);
      mem_rdata = (c == delay) ? rd : $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
    if (ld && !tmo) exp_result = res;
    check_eq("resp_done", 32'(done), 32'd1);
    check_eq("resp_req_low", 32'(mem_req), 32'd0);
    check_eq("resp_cause", 32'(err_cause), tmo ? 32'd3 : 32'd0);
    check_eq("resp_result", load_result, exp_result);
    @(posedge clk); #1;
    check_eq("post_done_low", 32'(done), 32'd0);
    check_eq("post_idle", 32'(busy), 32'd0);
    check_eq("post_result_held", load_result, exp_result);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [5];
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;

    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", load_result, 32'd0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan.
    run_op(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    run_op(1, 0, 3'd0, 32'h103, 32'h0, 32'h80F07F01, 1, 0);
    check_eq("lb_value", load_result, 32'hFFFFFF80);
    run_op(1, 0, 3'd4, 32'h103, 32'h0, 32'h80F07F01, 0, 0);
    check_eq("lbu_value", load_result, 32'h00000080);
    run_op(1, 0, 3'd1, 32'h102, 32'h0, 32'h80F07F01, 2, 0);
    check_eq("lh_value", load_result, 32'hFFFF80F0);
    run_op(0, 1, 3'd0, 32'h201, 32'h12345678, 32'h0, 3, 0);
    run_op(0, 1, 3'd1, 32'h202, 32'h12345678, 32'h0, 3, 0);
    check_eq("store_keeps_result", load_result, 32'hFFFF80F0);
    run_op(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
    run_op(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0);
    run_op(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0);
    run_op(0, 0, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 2, 1);

    if (TMO_EN) begin
      run_op(1, 0, 3'd2, 32'h400, 32'h0, 32'h11111111, 100, 0);
      run_op(1, 0, 3'd2, 32'h404, 32'h0, 32'h22222222, TMO - 1, 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [1:0] kind;
      logic [2:0] f3;
      kind = 2'($urandom_range(0, 9) == 0 ? $urandom_range(0, 1) * 3 : $urandom_range(1, 2));
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : f3_tab[$urandom_range(0, 4)];
      run_op(kind[0], kind[1], f3, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset while a request is outstanding.
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; address = 32'h500;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("pre_reset_req", 32'(mem_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_result = 32'h0;
    check_eq("arst_req", 32'(mem_req), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", load_result, 32'd0);
    check_eq("arst_cause", 32'(err_cause), 32'd0);
    check_eq("arst_addr", mem_addr, 32'd0);
    check_eq("arst_wdata", mem_wdata, 32'd0);
    check_eq("arst_wstrb", 32'(mem_wstrb), 32'd0);
    check_eq("arst_we", 32'(mem_we), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("after_rst_idle", 32'(busy), 32'd0);
    run_op(1, 0, 3'd5, 32'h602, 32'h0, 32'h9ABC1234, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
